// File: rtl/matrix_mult_pkg.sv
// rtl/matrix_mult_pkg.sv - shared types and default sizes for the matrix multiplier control path
// Contents: mm_state_e (FSM state encoding), mm_job_cfg_t (job descriptor),
//           default size constants and the descriptor field width MM_CW.
package matrix_mult_pkg;

  localparam int MM_WIDTH  = 8;
  localparam int MM_ROW    = 4;
  localparam int MM_COL    = 4;
  localparam int MM_W_SIZE = 256;
  localparam int MM_I_SIZE = 256;
  localparam int MM_O_SIZE = 256;

  // Descriptor counts/offsets are carried at a fixed width; the controller
  // truncates them to each memory's address width, which gives wrap-around.
  localparam int MM_CW = 16;

  // Encoding kept from the fixed 4x4 controller.
  typedef enum logic [2:0] {
    MM_IDLE   = 3'b000,
    MM_LOAD   = 3'b001,
    MM_IN     = 3'b011,
    MM_IN_OUT = 3'b010,
    MM_OUT    = 3'b110,
    MM_DONE   = 3'b111
  } mm_state_e;

  typedef struct packed {
    logic [MM_CW-1:0] w_rows_m1;
    logic [MM_CW-1:0] w_cols_m1;
    logic [MM_CW-1:0] i_rows_m1;
    logic [MM_CW-1:0] w_offset;
    logic [MM_CW-1:0] i_offset;
    logic [MM_CW-1:0] psum_offset;
    logic [MM_CW-1:0] o_offset;
    logic             accum_en;
    logic             reuse_w;
  } mm_job_cfg_t;

endpackage

// File: rtl/mm_lat_pipe.sv
// rtl/mm_lat_pipe.sv - PIPE_LAT-deep {valid, row index} delay line producing output and psum strobes
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid, in_idx        input-row issue strobe and row index (registered by the caller)
//   accum_en                enables psum reads
//   psum_offset, o_offset   base addresses, already at memory address width
//   wen_next                value o_wen takes on the next cycle
//   psum_ren, psum_addr     psum read, one cycle ahead of the matching write
//   o_wen, o_addr           output write, PIPE_LAT cycles after in_valid
module mm_lat_pipe
  import matrix_mult_pkg::*;
#(
  parameter int PIPE_LAT = 8,
  parameter int OA       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [MM_CW-1:0] in_idx,
  input  logic             accum_en,
  input  logic [OA-1:0]    psum_offset,
  input  logic [OA-1:0]    o_offset,
  output logic             wen_next,
  output logic             psum_ren,
  output logic [OA-1:0]    psum_addr,
  output logic             o_wen,
  output logic [OA-1:0]    o_addr
);

  // Stage s holds the issue from s cycles ago; the output registers form the
  // final stage, so o_wen lands exactly PIPE_LAT cycles after in_valid.
  logic [PIPE_LAT-1:1] v_q;
  logic [MM_CW-1:0]    idx_q [PIPE_LAT-1:1];
  logic                p_v;
  logic [MM_CW-1:0]    p_idx;

  // The psum tap sits one stage before the write tap; with a 2-deep pipe
  // that is the (already registered) input itself.
  generate
    if (PIPE_LAT == 2) begin : g_tap_in
      assign p_v   = in_valid;
      assign p_idx = in_idx;
    end else begin : g_tap_q
      assign p_v   = v_q[PIPE_LAT-2];
      assign p_idx = idx_q[PIPE_LAT-2];
    end
  endgenerate

  assign wen_next = v_q[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 1; s < PIPE_LAT; s++) idx_q[s] <= '0;
      o_wen     <= 1'b0;
      o_addr    <= '0;
      psum_ren  <= 1'b0;
      psum_addr <= '0;
    end else begin
      v_q[1]   <= in_valid;
      idx_q[1] <= in_idx;
      for (int s = 2; s < PIPE_LAT; s++) begin
        v_q[s]   <= v_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
      o_wen     <= v_q[PIPE_LAT-1];
      o_addr    <= v_q[PIPE_LAT-1] ? o_offset + OA'(idx_q[PIPE_LAT-1]) : '0;
      psum_ren  <= accum_en & p_v;
      psum_addr <= (accum_en && p_v) ? psum_offset + OA'(p_idx) : '0;
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// rtl/mm_seq_ctrl.sv - job sequencer for the weight-stationary systolic matrix multiplier
// Optional feature macro: MM_SEQ_CTRL_PERF_EN (adds perf_cycles / perf_jobs).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, cfg                 job request and descriptor (accepted only in IDLE)
//   w_ren, w_addr              weight memory read
//   weight_load_en             array weight shift, w_ren delayed one cycle
//   i_ren, i_addr              input memory read
//   psum_ren, psum_addr        psum memory read (accumulate jobs only)
//   o_wen, o_addr              output memory write
//   accum_sel                  adder takes psum operand
//   w_cols_m1                  latched column count for column masking
//   state, busy, done          FSM state, not-idle flag, one-cycle completion pulse
//   perf_cycles, perf_jobs     busy-cycle and job counters (MM_SEQ_CTRL_PERF_EN only)
module mm_seq_ctrl
  import matrix_mult_pkg::*;
#(
  parameter int WIDTH    = MM_WIDTH,
  parameter int ROW      = MM_ROW,
  parameter int COL      = MM_COL,
  parameter int W_SIZE   = MM_W_SIZE,
  parameter int I_SIZE   = MM_I_SIZE,
  parameter int O_SIZE   = MM_O_SIZE,
  parameter int PIPE_LAT = ROW + COL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  mm_job_cfg_t               cfg,
`ifdef MM_SEQ_CTRL_PERF_EN
  output logic [31:0]               perf_cycles,
  output logic [15:0]               perf_jobs,
`endif
  output logic                      w_ren,
  output logic [$clog2(W_SIZE)-1:0] w_addr,
  output logic                      weight_load_en,
  output logic                      i_ren,
  output logic [$clog2(I_SIZE)-1:0] i_addr,
  output logic                      psum_ren,
  output logic [$clog2(O_SIZE)-1:0] psum_addr,
  output logic                      o_wen,
  output logic [$clog2(O_SIZE)-1:0] o_addr,
  output logic                      accum_sel,
  output logic [MM_CW-1:0]          w_cols_m1,
  output mm_state_e                 state,
  output logic                      busy,
  output logic                      done
);

  localparam int WA = $clog2(W_SIZE);
  localparam int IA = $clog2(I_SIZE);
  localparam int OA = $clog2(O_SIZE);

  generate
    if (PIPE_LAT < 2 || ROW < 1 || COL < 1 || WIDTH < 1) begin : g_bad_params
      $error("mm_seq_ctrl: PIPE_LAT must be >= 2 and sizes >= 1");
    end
  endgenerate

  mm_job_cfg_t      cfg_q, cfg_d;
  logic [MM_CW-1:0] j_q, j_d;     // weight row counter
  logic [MM_CW-1:0] k_q, k_d;     // input issue counter
  mm_state_e        state_d;
  logic             w_ren_d, wle_d, i_ren_d, accum_d, busy_d, done_d;
  logic [WA-1:0]    w_addr_d;
  logic [IA-1:0]    i_addr_d;
  logic             wen_next;

  // Next-state and next-output logic. Every output is a register loaded from
  // these *_d values, so nothing combinational reaches a port from start/cfg.
  always_comb begin
    state_d  = state;
    cfg_d    = cfg_q;
    j_d      = j_q;
    k_d      = k_q;
    w_ren_d  = 1'b0;
    w_addr_d = '0;
    i_ren_d  = 1'b0;
    i_addr_d = '0;
    accum_d  = accum_sel;
    wle_d    = w_ren;

    case (state)
      MM_IDLE: begin
        if (start) begin
          cfg_d   = cfg;
          accum_d = cfg.accum_en;
          if (cfg.reuse_w) begin
            state_d  = MM_IN;
            i_ren_d  = 1'b1;
            k_d      = '0;
            i_addr_d = IA'(cfg.i_offset);
          end else begin
            state_d  = MM_LOAD;
            w_ren_d  = 1'b1;
            j_d      = '0;
            w_addr_d = WA'(cfg.w_offset);
          end
        end
      end

      MM_LOAD: begin
        if (w_ren && j_q != cfg_q.w_rows_m1) begin
          w_ren_d  = 1'b1;
          j_d      = j_q + 1'b1;
          w_addr_d = WA'(cfg_q.w_offset + j_q + 1'b1);
        end else if (weight_load_en && !w_ren) begin
          // Last weight shift is happening now; first issue follows.
          state_d  = MM_IN;
          i_ren_d  = 1'b1;
          k_d      = '0;
          i_addr_d = IA'(cfg_q.i_offset);
        end
      end

      MM_IN, MM_IN_OUT: begin
        if (i_ren && k_q != cfg_q.i_rows_m1) begin
          i_ren_d  = 1'b1;
          k_d      = k_q + 1'b1;
          i_addr_d = IA'(cfg_q.i_offset + k_q + 1'b1);
          // Writes start next cycle while issues continue: overlap phase.
          state_d  = wen_next ? MM_IN_OUT : MM_IN;
        end else begin
          state_d = MM_OUT;
        end
      end

      MM_OUT: begin
        if (o_wen && !wen_next) state_d = MM_DONE;
      end

      MM_DONE: state_d = MM_IDLE;

      default: state_d = MM_IDLE;
    endcase

    busy_d = (state_d != MM_IDLE);
    done_d = (state_d == MM_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= MM_IDLE;
      cfg_q          <= '0;
      j_q            <= '0;
      k_q            <= '0;
      w_ren          <= 1'b0;
      w_addr         <= '0;
      weight_load_en <= 1'b0;
      i_ren          <= 1'b0;
      i_addr         <= '0;
      accum_sel      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_d;
      cfg_q          <= cfg_d;
      j_q            <= j_d;
      k_q            <= k_d;
      w_ren          <= w_ren_d;
      w_addr         <= w_addr_d;
      weight_load_en <= wle_d;
      i_ren          <= i_ren_d;
      i_addr         <= i_addr_d;
      accum_sel      <= accum_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

  assign w_cols_m1 = cfg_q.w_cols_m1;

  mm_lat_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .OA       (OA)
  ) u_lat_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (i_ren),
    .in_idx      (k_q),
    .accum_en    (cfg_q.accum_en),
    .psum_offset (OA'(cfg_q.psum_offset)),
    .o_offset    (OA'(cfg_q.o_offset)),
    .wen_next    (wen_next),
    .psum_ren    (psum_ren),
    .psum_addr   (psum_addr),
    .o_wen       (o_wen),
    .o_addr      (o_addr)
  );

`ifdef MM_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      if (busy && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
      if (done) perf_jobs <= perf_jobs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb/tb_mm_seq_ctrl.sv - directed self-checking bench for mm_seq_ctrl
module tb_mm_seq_ctrl;
  import matrix_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  mm_job_cfg_t cfg;
  logic        w_ren, weight_load_en, i_ren, psum_ren, o_wen, accum_sel, busy, done;
  logic [7:0]  w_addr, i_addr, psum_addr, o_addr;
  logic [15:0] w_cols_m1;
  mm_state_e   state;
`ifdef MM_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_jobs;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mm_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg            (cfg),
`ifdef MM_SEQ_CTRL_PERF_EN
    .perf_cycles    (perf_cycles),
    .perf_jobs      (perf_jobs),
`endif
    .w_ren          (w_ren),
    .w_addr         (w_addr),
    .weight_load_en (weight_load_en),
    .i_ren          (i_ren),
    .i_addr         (i_addr),
    .psum_ren       (psum_ren),
    .psum_addr      (psum_addr),
    .o_wen          (o_wen),
    .o_addr         (o_addr),
    .accum_sel      (accum_sel),
    .w_cols_m1      (w_cols_m1),
    .state          (state),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {21'd0, state, busy, done, w_ren, w_addr, weight_load_en, i_ren, i_addr,
            psum_ren, psum_addr, o_wen, o_addr, accum_sel};
  endfunction

  // Expected outputs at cycle c after the start edge, from the job timing
  // (PIPE_LAT = 8, 256-deep memories).
  function automatic logic [63:0] exp_vec(input int c, input int wr, input int ir,
                                          input int woff, input int ioff, input int poff,
                                          input int ooff, input bit acc, input bit reuse);
    int        lat, bi, dc;
    mm_state_e st;
    bit        wren, wle, iren, pren, owen;
    logic [7:0] wa, ia, pa, oa;
    lat  = 8;
    bi   = reuse ? 1 : wr + 3;
    dc   = bi + ir + 1 + lat;
    wren = !reuse && c >= 1 && c <= wr + 1;
    wa   = wren ? 8'(woff + c - 1) : 8'd0;
    wle  = !reuse && c >= 2 && c <= wr + 2;
    iren = c >= bi && c <= bi + ir;
    ia   = iren ? 8'(ioff + c - bi) : 8'd0;
    pren = acc && c >= bi + lat - 1 && c <= bi + ir + lat - 1;
    pa   = pren ? 8'(poff + c - bi - lat + 1) : 8'd0;
    owen = c >= bi + lat && c <= bi + ir + lat;
    oa   = owen ? 8'(ooff + c - bi - lat) : 8'd0;
    if (c < 1 || c > dc)     st = MM_IDLE;
    else if (c < bi)         st = MM_LOAD;
    else if (c <= bi + ir)   st = (c >= bi + lat) ? MM_IN_OUT : MM_IN;
    else if (c < dc)         st = MM_OUT;
    else                     st = MM_DONE;
    return {21'd0, st, (c >= 1 && c <= dc), (c == dc), wren, wa, wle, iren, ia,
            pren, pa, owen, oa, acc};
  endfunction

  // Starts one job from IDLE and checks every output each cycle until three
  // cycles after the expected done. Optionally pulses start mid-job (mid_at),
  // in the DONE cycle (sdone), or aborts with reset (abort_at).
  task automatic run_job(input string tag, input int wr, input int ir, input int woff,
                         input int ioff, input int poff, input int ooff, input bit acc,
                         input bit reuse, input int mid_at, input bit sdone, input int abort_at,
                         output int dcyc, output int ndone, output int noen, output bit inout_seen);
    int bi, dc;
    logic [63:0] e;
    bi = reuse ? 1 : wr + 3;
    dc = bi + ir + 1 + 8;
    dcyc = 0; ndone = 0; noen = 0; inout_seen = 1'b0;
    cfg = '0;
    cfg.w_rows_m1   = 16'(wr);
    cfg.w_cols_m1   = 16'd3;
    cfg.i_rows_m1   = 16'(ir);
    cfg.w_offset    = 16'(woff);
    cfg.i_offset    = 16'(ioff);
    cfg.psum_offset = 16'(poff);
    cfg.o_offset    = 16'(ooff);
    cfg.accum_en    = acc;
    cfg.reuse_w     = reuse;
    start = 1'b1;
    for (int c = 1; c <= dc + 3; c++) begin
      @(negedge clk);
      if (abort_at > 0 && c > abort_at) e = '0;
      else e = exp_vec(c, wr, ir, woff, ioff, poff, ooff, acc, reuse);
      chk($sformatf("%s_c%0d", tag, c), dut_vec(), e);
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = c;
      end
      if (o_wen) noen++;
      if (state == MM_IN_OUT) inout_seen = 1'b1;
      start = (c == mid_at) || (sdone && c == dc);
      if (c == mid_at) cfg = '1;
      rst_n = !(abort_at > 0 && c == abort_at);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  int dcyc, ndone, noen;
  bit inout_seen;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg   = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", dut_vec(), 64'd0);
    chk("reset_w_cols", {48'd0, w_cols_m1}, 64'd0);
`ifdef MM_SEQ_CTRL_PERF_EN
    chk("reset_perf", {16'd0, perf_jobs, perf_cycles}, 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", dut_vec(), 64'd0);

    // Basic job, twice.
    run_job("basic", 3, 7, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, dcyc, ndone, noen, inout_seen);
    chk("basic_done_cycle", 64'(dcyc), 64'd22);
    chk("basic_done_count", 64'(ndone), 64'd1);
    chk("basic_writes", 64'(noen), 64'd8);
    chk("basic_no_in_out", 64'(inout_seen), 64'd0);
    chk("basic_w_cols", {48'd0, w_cols_m1}, 64'd3);
    run_job("basic2", 3, 7, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, dcyc, ndone, noen, inout_seen);
    chk("basic2_done_cycle", 64'(dcyc), 64'd22);
`ifdef MM_SEQ_CTRL_PERF_EN
    chk("perf_jobs", {48'd0, perf_jobs}, 64'd2);
    chk("perf_cycles", {32'd0, perf_cycles}, 64'd44);
`endif

    // Weight reuse: no LOAD phase, done five cycles earlier.
    run_job("reuse", 3, 7, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0, 0, dcyc, ndone, noen, inout_seen);
    chk("reuse_done_cycle", 64'(dcyc), 64'd17);

    // Short job: IN straight to OUT.
    run_job("short", 3, 1, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, dcyc, ndone, noen, inout_seen);
    chk("short_done_cycle", 64'(dcyc), 64'd16);
    chk("short_writes", 64'(noen), 64'd2);
    chk("short_no_in_out", 64'(inout_seen), 64'd0);

    // Accumulate with address wrap on every memory.
    run_job("accwrap", 1, 3, 255, 254, 254, 255, 1'b1, 1'b0, 0, 1'b0, 0, dcyc, ndone, noen, inout_seen);
    chk("accwrap_done_cycle", 64'(dcyc), 64'd16);
    chk("accwrap_writes", 64'(noen), 64'd4);

    // Long job with overlap phase; start pulsed mid-job and in DONE is dropped.
    run_job("overlap", 2, 9, 4, 8, 0, 16, 1'b0, 1'b0, 8, 1'b1, 0, dcyc, ndone, noen, inout_seen);
    chk("overlap_done_cycle", 64'(dcyc), 64'd23);
    chk("overlap_done_count", 64'(ndone), 64'd1);
    chk("overlap_writes", 64'(noen), 64'd10);
    chk("overlap_in_out_seen", 64'(inout_seen), 64'd1);

    // Reset during IN_OUT (cycle 15 of a 12-row job) aborts with no done.
    run_job("abort", 3, 11, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 15, dcyc, ndone, noen, inout_seen);
    chk("abort_done_count", 64'(ndone), 64'd0);
    chk("abort_in_out_seen", 64'(inout_seen), 64'd1);
    @(negedge clk);
    chk("abort_idle", dut_vec(), 64'd0);
`ifdef MM_SEQ_CTRL_PERF_EN
    chk("abort_perf_cleared", {16'd0, perf_jobs, 32'd0}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
